// File: rtl/sm_dot_mac_pkg.sv
// rtl/sm_dot_mac_pkg.sv - shared FSM encodings and sign-magnitude helpers for the dot-product MAC
package sm_dot_mac_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_MULT  = 2'd1;
    localparam logic [1:0] ST_ACCUM = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // A zero magnitude always carries a positive sign.
    function automatic logic sm_neg0_fix(input logic s, input logic nonzero);
        return s & nonzero;
    endfunction

    function automatic logic sm_mul(input logic sa, input logic sb, input logic nonzero);
        return sm_neg0_fix(sa ^ sb, nonzero);
    endfunction

endpackage

// File: rtl/sm_dot_mac_if.sv
// rtl/sm_dot_mac_if.sv - operand/result handshake bundle for the dot-product MAC
interface sm_dot_mac_if #(
    parameter int A_BITWIDTH   = 8,
    parameter int B_BITWIDTH   = A_BITWIDTH,
    parameter int LANES        = 4,
    parameter int ACC_BITWIDTH = 24
);
    logic                          in_valid;
    logic                          in_ready;
    logic                          in_first;
    logic                          in_last;
    logic [LANES*A_BITWIDTH-1:0]   data_a;
    logic [LANES*B_BITWIDTH-1:0]   data_b;
    logic [ACC_BITWIDTH-1:0]       bias;
    logic                          out_valid;
    logic                          out_ready;
    logic [ACC_BITWIDTH-1:0]       mout;
    logic                          sat;

    modport master (
        output in_valid, in_first, in_last, data_a, data_b, bias, out_ready,
        input  in_ready, out_valid, mout, sat
    );

    modport slave (
        input  in_valid, in_first, in_last, data_a, data_b, bias, out_ready,
        output in_ready, out_valid, mout, sat
    );
endinterface

// File: rtl/sm_dot_mac_sm_add_sat.sv
// rtl/sm_dot_mac_sm_add_sat.sv - combinational sign-magnitude adder with magnitude clamp
module sm_add_sat
    import sm_dot_mac_pkg::*;
#(
    parameter int W = 24
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y,
    output logic         ovf
);
    localparam int M = W - 1;

    logic [M:0]   sum;
    logic [M-1:0] mag;
    logic         s;

    always_comb begin
        sum = {1'b0, a[M-1:0]} + {1'b0, b[M-1:0]};
        ovf = 1'b0;
        mag = '0;
        s   = 1'b0;
        if (a[M] == b[M]) begin
            s = a[M];
            if (sum[M]) begin
                ovf = 1'b1;
                mag = '1;
            end else begin
                mag = sum[M-1:0];
            end
        end else if (a[M-1:0] >= b[M-1:0]) begin
            s   = a[M];
            mag = a[M-1:0] - b[M-1:0];
        end else begin
            s   = b[M];
            mag = b[M-1:0] - a[M-1:0];
        end
        y = {sm_neg0_fix(s, |mag), mag};
    end
endmodule

// File: rtl/sm_dot_mac.sv
// rtl/sm_dot_mac.sv - multi-lane sign-magnitude dot-product MAC, one lane accumulated per cycle
module sm_dot_mac
    import sm_dot_mac_pkg::*;
#(
    parameter int A_BITWIDTH   = 8,
    parameter int B_BITWIDTH   = A_BITWIDTH,
    parameter int LANES        = 4,
    parameter int ACC_BITWIDTH = 24
) (
    input  logic         clk,
    input  logic         rstn,
    sm_dot_mac_if.slave  bus
);
    localparam int AM   = A_BITWIDTH - 1;
    localparam int BM   = B_BITWIDTH - 1;
    localparam int PW   = AM + BM;
    localparam int LC_W = (LANES > 1) ? $clog2(LANES) : 1;

    logic [1:0]                  state_q, state_d;
    logic [LANES*A_BITWIDTH-1:0] a_q, a_d;
    logic [LANES*B_BITWIDTH-1:0] b_q, b_d;
    logic [ACC_BITWIDTH-1:0]     bias_q, bias_d;
    logic                        first_q, first_d;
    logic                        last_q, last_d;
    logic [PW:0]                 prod_q [LANES];
    logic [PW:0]                 prod_d [LANES];
    logic [ACC_BITWIDTH-1:0]     acc_q, acc_d;
    logic                        sat_q, sat_d;
    logic [LC_W-1:0]             lane_cnt_q, lane_cnt_d;

    logic [ACC_BITWIDTH-1:0]     bias_fix;
    logic [ACC_BITWIDTH-1:0]     add_b;
    logic [ACC_BITWIDTH-1:0]     add_y;
    logic                        add_ovf;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [PW-1:0] mag;
        assign mag = PW'(a_q[i*A_BITWIDTH +: AM]) * PW'(b_q[i*B_BITWIDTH +: BM]);
        assign prod_d[i] = (state_q == ST_MULT)
                         ? {sm_mul(a_q[i*A_BITWIDTH + AM], b_q[i*B_BITWIDTH + BM], |mag), mag}
                         : prod_q[i];
    end

    assign bias_fix = {sm_neg0_fix(bias_q[ACC_BITWIDTH-1], |bias_q[ACC_BITWIDTH-2:0]),
                       bias_q[ACC_BITWIDTH-2:0]};
    assign add_b    = {prod_q[lane_cnt_q][PW], (ACC_BITWIDTH-1)'(prod_q[lane_cnt_q][PW-1:0])};

    sm_add_sat #(.W(ACC_BITWIDTH)) u_add (
        .a   (acc_q),
        .b   (add_b),
        .y   (add_y),
        .ovf (add_ovf)
    );

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        bias_d     = bias_q;
        first_d    = first_q;
        last_d     = last_q;
        acc_d      = acc_q;
        sat_d      = sat_q;
        lane_cnt_d = lane_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.data_a;
                    b_d     = bus.data_b;
                    bias_d  = bus.bias;
                    first_d = bus.in_first;
                    last_d  = bus.in_last;
                    state_d = ST_MULT;
                end
            end
            ST_MULT: begin
                acc_d      = first_q ? bias_fix : acc_q;
                sat_d      = first_q ? 1'b0 : sat_q;
                lane_cnt_d = '0;
                state_d    = ST_ACCUM;
            end
            ST_ACCUM: begin
                acc_d      = add_y;
                sat_d      = sat_q | add_ovf;
                lane_cnt_d = lane_cnt_q + 1'b1;
                if (lane_cnt_q == LC_W'(LANES - 1)) begin
                    state_d = last_q ? ST_DONE : ST_IDLE;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            bias_q     <= '0;
            first_q    <= 1'b0;
            last_q     <= 1'b0;
            acc_q      <= '0;
            sat_q      <= 1'b0;
            lane_cnt_q <= '0;
            for (int i = 0; i < LANES; i++) begin
                prod_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            bias_q     <= bias_d;
            first_q    <= first_d;
            last_q     <= last_d;
            acc_q      <= acc_d;
            sat_q      <= sat_d;
            lane_cnt_q <= lane_cnt_d;
            for (int i = 0; i < LANES; i++) begin
                prod_q[i] <= prod_d[i];
            end
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.mout      = acc_q;
    assign bus.sat       = sat_q;
endmodule

// File: tb/tb_sm_dot_mac.sv
// tb/tb_sm_dot_mac.sv - directed and randomized checks of sm_dot_mac against an integer model
module tb_sm_dot_mac;
    localparam int     A     = 8;
    localparam int     LANES = 4;
    localparam int     ACC   = 24;
    localparam longint MAXV  = (longint'(1) << (ACC - 1)) - 1;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    sm_dot_mac_if #(.A_BITWIDTH(A), .B_BITWIDTH(A), .LANES(LANES), .ACC_BITWIDTH(ACC)) bus ();

    sm_dot_mac #(.A_BITWIDTH(A), .B_BITWIDTH(A), .LANES(LANES), .ACC_BITWIDTH(ACC)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int        n_checks  = 0;
    int        n_fail    = 0;
    int        cyc       = 0;
    int        acc_cyc   = 0;
    int        n_results = 0;
    longint    m_acc     = 0;
    bit        m_sat     = 1'b0;
    logic [ACC-1:0] last_mout;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rstn && bus.out_valid && bus.out_ready) n_results = n_results + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic longint sm_val(input logic [31:0] v, input int w);
        longint mag;
        mag = longint'(v) & ((longint'(1) << (w - 1)) - 1);
        return v[w-1] ? -mag : mag;
    endfunction

    function automatic logic [ACC-1:0] to_sm(input longint v);
        logic [ACC-1:0] r;
        if (v < 0) r = {1'b1, (ACC-1)'(-v)};
        else       r = {1'b0, (ACC-1)'(v)};
        return r;
    endfunction

    task automatic model_beat(input bit first, input logic [31:0] a, input logic [31:0] b,
                              input logic [ACC-1:0] bias);
        if (first) begin
            m_acc = sm_val(32'(bias), ACC);
            m_sat = 1'b0;
        end
        for (int i = 0; i < LANES; i++) begin
            m_acc = m_acc + sm_val(32'(a[i*A +: A]), A) * sm_val(32'(b[i*A +: A]), A);
            if (m_acc > MAXV) begin
                m_acc = MAXV;
                m_sat = 1'b1;
            end else if (m_acc < -MAXV) begin
                m_acc = -MAXV;
                m_sat = 1'b1;
            end
        end
    endtask

    task automatic drive_beat(input bit first, input bit last, input logic [31:0] a,
                              input logic [31:0] b, input logic [ACC-1:0] bias);
        int t;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_first = first;
        bus.in_last  = last;
        bus.data_a   = a;
        bus.data_b   = b;
        bus.bias     = bias;
        t = 0;
        while (!bus.in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) check("in_ready_timeout", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        acc_cyc      = cyc;
        bus.in_valid = 1'b0;
        model_beat(first, a, b, bias);
    endtask

    task automatic expect_result(input string tag);
        int t;
        t = 0;
        while (!bus.out_valid && t < 40) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        check({tag, "_latency"}, 32'(cyc - acc_cyc), 32'(LANES + 1));
        check({tag, "_mout"}, 32'(bus.mout), 32'(to_sm(m_acc)));
        check({tag, "_sat"}, 32'(bus.sat), 32'(m_sat));
        last_mout = bus.mout;
        if (bus.out_ready) begin
            @(negedge clk);
            check({tag, "_drop"}, 32'(bus.out_valid), 32'd0);
        end
    endtask

    initial begin
        int            nres;
        int            nbeats;
        logic [23:0]   rbias;
        logic          rsat;
        bit            rfirst;

        rstn          = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_first  = 1'b0;
        bus.in_last   = 1'b0;
        bus.data_a    = '0;
        bus.data_b    = '0;
        bus.bias      = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_mout", 32'(bus.mout), 32'd0);
        check("rst_sat", 32'(bus.sat), 32'd0);

        // single beat mixed signs
        drive_beat(1'b1, 1'b1, 32'h01_00_82_03, 32'h81_07_05_04, 24'h0);
        expect_result("single");
        check("single_const", 32'(last_mout), 32'h000001);

        // saturation, then a fresh packet clears sat
        drive_beat(1'b1, 1'b1, 32'h00_00_00_01, 32'h00_00_00_01, 24'h7FFFFF);
        expect_result("satur");
        check("satur_const", 32'(last_mout), 32'h7FFFFF);
        check("satur_flag", 32'(bus.sat), 32'd1);
        drive_beat(1'b1, 1'b1, 32'h00_00_00_02, 32'h00_00_00_03, 24'h0);
        expect_result("satclr");
        check("satclr_flag", 32'(bus.sat), 32'd0);

        // reset during ACCUM
        drive_beat(1'b1, 1'b1, 32'h00_00_00_01, 32'h00_00_00_01, 24'h7FFFFF);
        nres = n_results;
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        m_acc = 0;
        m_sat = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_mout", 32'(bus.mout), 32'd0);
        check("midrst_sat", 32'(bus.sat), 32'd0);
        check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        repeat (8) @(negedge clk);
        check("midrst_no_result", 32'(n_results), 32'(nres));

        // exact cancellation to +0
        drive_beat(1'b1, 1'b1, 32'h00_00_00_05, 32'h00_00_00_05, 24'h800019);
        expect_result("cancel");
        check("cancel_const", 32'(last_mout), 32'h000000);

        // three-beat packet
        nres = n_results;
        drive_beat(1'b1, 1'b0, 32'h7F7F7F7F, 32'h7F7F7F7F, 24'h0);
        drive_beat(1'b0, 1'b0, 32'h7F7F7F7F, 32'h7F7F7F7F, 24'h123456);
        drive_beat(1'b0, 1'b1, 32'h7F7F7F7F, 32'h7F7F7F7F, 24'h0);
        check("pkt3_no_early", 32'(n_results), 32'(nres));
        expect_result("pkt3");
        check("pkt3_const", 32'(last_mout), 32'h02F40C);
        check("pkt3_one_result", 32'(n_results), 32'(nres + 1));

        // backpressure with in_valid held high
        bus.out_ready = 1'b0;
        drive_beat(1'b1, 1'b1, 32'h83_12_40_7F, 32'h05_91_22_7E, 24'h800100);
        expect_result("bp");
        rsat = bus.sat;
        nres = n_results;
        bus.in_valid = 1'b1;
        bus.in_first = 1'b1;
        bus.in_last  = 1'b1;
        bus.data_a   = 32'h7F7F7F7F;
        bus.data_b   = 32'h7F7F7F7F;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_hold_valid", 32'(bus.out_valid), 32'd1);
            check("bp_hold_mout", 32'(bus.mout), 32'(last_mout));
            check("bp_hold_sat", 32'(bus.sat), 32'(rsat));
            check("bp_hold_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("bp_release_valid", 32'(bus.out_valid), 32'd0);
        check("bp_release_idle", 32'(bus.in_ready), 32'd1);
        check("bp_one_result", 32'(n_results), 32'(nres + 1));
        drive_beat(1'b0, 1'b1, 32'h00_00_00_03, 32'h00_00_00_03, 24'h0);
        expect_result("bp_follow");

        // randomized packets
        for (int p = 0; p < 30; p++) begin
            nbeats = $urandom_range(1, 3);
            for (int k = 0; k < nbeats; k++) begin
                rbias = 24'($urandom());
                if ($urandom_range(0, 3) == 0)
                    rbias = {1'($urandom_range(0, 1)), 23'h7FFF00 | 23'($urandom_range(0, 255))};
                rfirst = (k == 0) && (p % 5 != 4);
                drive_beat(rfirst, k == nbeats - 1, $urandom(), $urandom(), rbias);
            end
            expect_result("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
